// File: rtl/uart_tx_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo_ctrl : TX byte FIFO feeding a one-byte-at-a-time UART launcher.
// Option macro UART_TX_FIFO_OVF_FLAG_EN adds ovf_clr/overflow.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  ,
  input  logic                  ovf_clr,
  output logic                  overflow
`endif
);

  localparam int                  c_depth     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth_cnt = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_cnt_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);
  localparam logic [1:0]          c_to_last   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [c_depth];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [1:0]            to_cnt_q, to_cnt_d;
  logic                  w_wr_acc;
  logic                  w_pop;

  // Launch FSM; a frame whose busy never appears is abandoned after 4 cycles.
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    to_cnt_d   = to_cnt_q;
    w_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          w_pop      = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          to_cnt_d   = 2'd0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (to_cnt_q == c_to_last) begin
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 2'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A write while full is dropped regardless of a same-cycle pop.
  always_comb begin
    w_wr_acc = wr_en && !full_q;
    wr_ptr_d = w_wr_acc ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
    rd_ptr_d = w_pop ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
    count_d  = count_q;
    if (w_wr_acc && !w_pop) begin
      count_d = count_q + c_cnt_one;
    end else if (!w_wr_acc && w_pop) begin
      count_d = count_q - c_cnt_one;
    end
    full_d  = (count_d == c_depth_cnt);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      to_cnt_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic overflow_q, overflow_d;

  // Sticky; a drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_en && full_q) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo_ctrl : directed bench for uart_tx_fifo_ctrl with a TX model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_fifo_ctrl;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       wr_en   = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic       ovf_clr = 1'b0;
  logic       overflow;
`endif

  logic       model_en   = 1'b0;
  logic       model_busy = 1'b0;
  logic       bench_busy = 1'b0;
  int         busy_len   = 10;
  int         m_dly      = 0;
  int         m_hold     = 0;
  logic       prev_start = 1'b0;
  logic [7:0] q [$];
  int         n_checks   = 0;
  int         n_errors   = 0;

  assign tx_busy = model_en ? model_busy : bench_busy;

  always #5 clk = ~clk;

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );
`else
  uart_tx_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until n launches are seen and the transmitter model has gone quiet.
  task automatic wait_drain(input int n, input int max_cyc);
    int c;
    c = 0;
    while ((q.size() < n || tx_busy || m_dly != 0 || !empty) && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    if (c >= max_cyc) check("drain_timeout", 32'd0, 32'd1);
    tick(3);
  endtask

  // Transmitter: busy rises two cycles after a launch and holds busy_len cycles.
  always @(negedge clk) begin
    if (!model_en) begin
      model_busy = 1'b0;
      m_dly      = 0;
      m_hold     = 0;
    end else if (tx_start) begin
      m_dly = 2;
    end else if (m_dly > 0) begin
      m_dly--;
      if (m_dly == 0) begin
        model_busy = 1'b1;
        m_hold     = busy_len;
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) model_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      q.push_back(tx_data);
      check("start_width", 32'(prev_start), 32'd0);
    end
    prev_start = tx_start;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick(2);
    rst = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
`ifdef UART_TX_FIFO_OVF_FLAG_EN
    check("rst_ovf", 32'(overflow), 32'd0);
`endif

    // 1: single byte, two-cycle latency, long frame
    busy_len = 160;
    model_en = 1'b1;
    wr_en    = 1'b1;
    wr_data  = 8'h55;
    tick(1);
    wr_en = 1'b0;
    check("t1_count1", 32'(count), 32'd1);
    check("t1_empty0", 32'(empty), 32'd0);
    check("t1_nostart", 32'(tx_start), 32'd0);
    tick(1);
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'h55);
    check("t1_count0", 32'(count), 32'd0);
    wait_drain(1, 1000);
    check("t1_pulses", 32'(q.size()), 32'd1);
    check("t1_q0", 32'(q[0]), 32'h55);
    check("t1_hold", 32'(tx_data), 32'h55);

    // 2: park the FSM in WAIT_DONE, then fill to full and overflow
    model_en   = 1'b0;
    bench_busy = 1'b1;
    q.delete();
    wr_en   = 1'b1;
    wr_data = 8'hA0;
    tick(1);
    wr_en = 1'b0;
    tick(3);
    check("t2_dummy_n", 32'(q.size()), 32'd1);
    check("t2_dummy_d", 32'(q[0]), 32'hA0);
    check("t2_empty", 32'(empty), 32'd1);
    q.delete();
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_data = 8'(i);
      tick(1);
      if (i == 7) begin
        check("t2_count7", 32'(count), 32'd7);
        check("t2_notfull7", 32'(full), 32'd0);
      end
    end
    check("t2_count8", 32'(count), 32'd8);
    check("t2_full", 32'(full), 32'd1);
    check("t2_notempty", 32'(empty), 32'd0);
    wr_data = 8'h09;
    tick(1);
    wr_en = 1'b0;
    check("t2_drop_count", 32'(count), 32'd8);
    check("t2_drop_full", 32'(full), 32'd1);
`ifdef UART_TX_FIFO_OVF_FLAG_EN
    check("t2_ovf_set", 32'(overflow), 32'd1);
    tick(1);
    check("t2_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    check("t2_ovf_clr", 32'(overflow), 32'd0);
    wr_en = 1'b1;
    tick(1);
    wr_en = 1'b0;
    check("t2_ovf_setwins", 32'(overflow), 32'd1);
    tick(1);
    ovf_clr = 1'b0;
    check("t2_ovf_clr2", 32'(overflow), 32'd0);
    check("t2_ovf_count", 32'(count), 32'd8);
`endif

    // 3: drain in order
    bench_busy = 1'b0;
    busy_len   = 10;
    model_en   = 1'b1;
    wait_drain(8, 2000);
    check("t3_pulses", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("t3_order", 32'(q[i]), 32'(i + 1));
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_count", 32'(count), 32'd0);
    check("t3_notfull", 32'(full), 32'd0);

    // 4: write coincident with a pop at count=3
    model_en   = 1'b0;
    bench_busy = 1'b1;
    q.delete();
    wr_en = 1'b1;
    wr_data = 8'hB0; tick(1);
    wr_data = 8'hB1; tick(1);
    wr_data = 8'hB2; tick(1);
    wr_data = 8'hB3; tick(1);
    wr_en = 1'b0;
    check("t4_count3", 32'(count), 32'd3);
    bench_busy = 1'b0;
    tick(1);
    check("t4_wait_count", 32'(count), 32'd3);
    wr_en      = 1'b1;
    wr_data    = 8'hC0;
    bench_busy = 1'b1;
    tick(1);
    wr_en = 1'b0;
    check("t4_start", 32'(tx_start), 32'd1);
    check("t4_data", 32'(tx_data), 32'hB1);
    check("t4_count_same", 32'(count), 32'd3);
    tick(1);
    bench_busy = 1'b0;
    busy_len   = 5;
    model_en   = 1'b1;
    wait_drain(5, 1000);
    check("t4_pulses", 32'(q.size()), 32'd5);
    check("t4_q2", 32'(q[2]), 32'hB2);
    check("t4_q3", 32'(q[3]), 32'hB3);
    check("t4_tail", 32'(q[4]), 32'hC0);

    // 5: busy never rises -> abandon after 4 cycles, next byte launches
    model_en   = 1'b0;
    bench_busy = 1'b0;
    wr_en   = 1'b1;
    wr_data = 8'hD0; tick(1);
    wr_data = 8'hD1; tick(1);
    wr_en = 1'b0;
    check("t5_start0", 32'(tx_start), 32'd1);
    check("t5_data0", 32'(tx_data), 32'hD0);
    check("t5_count1", 32'(count), 32'd1);
    tick(3);
    check("t5_wait_nostart", 32'(tx_start), 32'd0);
    check("t5_wait_count", 32'(count), 32'd1);
    tick(1);
    check("t5_idle_nostart", 32'(tx_start), 32'd0);
    check("t5_idle_count", 32'(count), 32'd1);
    tick(1);
    check("t5_start1", 32'(tx_start), 32'd1);
    check("t5_data1", 32'(tx_data), 32'hD1);
    check("t5_count0", 32'(count), 32'd0);
    tick(6);

    // 6: reset in WAIT_DONE with 5 queued
    bench_busy = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'hE0 + i);
      tick(1);
    end
    wr_en = 1'b0;
    check("t6_count5", 32'(count), 32'd5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6_count", 32'(count), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_full", 32'(full), 32'd0);
    check("t6_start", 32'(tx_start), 32'd0);
    check("t6_data", 32'(tx_data), 32'h00);
    bench_busy = 1'b0;
    q.delete();
    tick(6);
    check("t6_no_launch", 32'(q.size()), 32'd0);
    check("t6_still_empty", 32'(empty), 32'd1);
    wr_en   = 1'b1;
    wr_data = 8'h77;
    tick(1);
    wr_en = 1'b0;
    check("t6_new_count", 32'(count), 32'd1);
    tick(1);
    check("t6_new_start", 32'(tx_start), 32'd1);
    check("t6_new_data", 32'(tx_data), 32'h77);
    tick(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
